// File: rtl/rice_core_pkg.sv
// Shared types and helpers for the rice_core execute-stage multiply/divide unit.
package rice_core_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } rice_core_muldiv_command;

  typedef enum logic [1:0] {
    MULDIV_IDLE = 2'd0,
    MULDIV_CALC = 2'd1,
    MULDIV_DONE = 2'd2
  } rice_core_muldiv_state;

  function automatic logic is_mul_command(input rice_core_muldiv_command command);
    case (command)
      DIV, DIVU, REM, REMU: return 1'b0;
      default:              return 1'b1;
    endcase
  endfunction

  function automatic logic is_rem_command(input rice_core_muldiv_command command);
    return (command == REM) || (command == REMU);
  endfunction

  function automatic logic is_signed_rs1(input rice_core_muldiv_command command);
    case (command)
      MULHU, DIVU, REMU: return 1'b0;
      default:           return 1'b1;
    endcase
  endfunction

  function automatic logic is_signed_rs2(input rice_core_muldiv_command command);
    case (command)
      MULHSU, MULHU, DIVU, REMU: return 1'b0;
      default:                   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/rice_core_muldiv_step.sv
// One radix-2 iteration on the {hi,lo} accumulator: LSB-first shift-add for
// multiply, or shift-left plus trial subtract for restoring division.
module rice_core_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_mul,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Remainder stays below the divisor, so diff[XLEN] is a true borrow flag.
  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, operand};
    if (is_mul) begin
      hi_next = add_sum[XLEN:1];
      lo_next = {add_sum[0], lo[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      hi_next = diff[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], 1'b1};
    end else begin
      hi_next = shifted[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/rice_core_muldiv.sv
// Iterative RV M-extension multiply/divide unit with valid/ready on both sides.
// Define RICE_CORE_MULDIV_FAST_PATH_EN to finish trivial operations without iterating.
module rice_core_muldiv
  import rice_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [XLEN-1:0]         i_rs1_value,
  input  logic [XLEN-1:0]         i_rs2_value,
  input  rice_core_muldiv_command i_command,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [XLEN-1:0]         o_result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  rice_core_muldiv_state   state, next_state;
  rice_core_muldiv_command command_q;
  logic [XLEN-1:0]         hi_q, lo_q, operand_q;
  logic [CNT_W-1:0]        count_q;
  logic                    negate_q;

  logic                    accept, step_en, last_step;
  logic                    rs1_neg, rs2_neg, div_zero, overflow, negate_d;
  logic [XLEN-1:0]         rs1_mag, rs2_mag;
  logic [XLEN-1:0]         step_hi, step_lo;
  logic [2*XLEN-1:0]       product;
  logic [XLEN-1:0]         div_value, final_result;
  logic                    fast_hit;

  assign accept    = (state == MULDIV_IDLE) && i_valid && !i_flush;
  assign step_en   = (state == MULDIV_CALC) && !i_flush;
  assign last_step = step_en && (count_q == LAST_STEP);

  // Magnitudes and the result sign; a zero divisor keeps the quotient all ones
  // and the remainder sign-restored back to rs1, overflow falls out naturally.
  always_comb begin
    rs1_neg  = is_signed_rs1(i_command) && i_rs1_value[XLEN-1];
    rs2_neg  = is_signed_rs2(i_command) && i_rs2_value[XLEN-1];
    rs1_mag  = rs1_neg ? -i_rs1_value : i_rs1_value;
    rs2_mag  = rs2_neg ? -i_rs2_value : i_rs2_value;
    div_zero = (i_rs2_value == '0);
    overflow = !is_mul_command(i_command) && is_signed_rs1(i_command) &&
               (i_rs1_value == MIN_INT) && (i_rs2_value == '1);
    if (is_mul_command(i_command)) begin
      negate_d = rs1_neg ^ rs2_neg;
    end else if (is_rem_command(i_command)) begin
      negate_d = rs1_neg;
    end else begin
      negate_d = (rs1_neg ^ rs2_neg) && !div_zero;
    end
  end

`ifdef RICE_CORE_MULDIV_FAST_PATH_EN
  logic [XLEN-1:0] fast_result;

  always_comb begin
    fast_hit    = 1'b0;
    fast_result = '0;
    if (is_mul_command(i_command)) begin
      fast_hit = (i_rs1_value == '0) || (i_rs2_value == '0);
    end else if (div_zero) begin
      fast_hit    = 1'b1;
      fast_result = is_rem_command(i_command) ? i_rs1_value : '1;
    end else if (overflow) begin
      fast_hit    = 1'b1;
      fast_result = is_rem_command(i_command) ? '0 : i_rs1_value;
    end
  end
`else
  assign fast_hit = 1'b0;
`endif

  rice_core_muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .is_mul (is_mul_command(command_q)),
    .hi     (hi_q),
    .lo     (lo_q),
    .operand(operand_q),
    .hi_next(step_hi),
    .lo_next(step_lo)
  );

  always_comb begin
    product   = negate_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    div_value = is_rem_command(command_q) ? step_hi : step_lo;
    div_value = negate_q ? -div_value : div_value;
    if (!is_mul_command(command_q)) begin
      final_result = div_value;
    end else if (command_q == MUL) begin
      final_result = product[XLEN-1:0];
    end else begin
      final_result = product[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= MULDIV_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      MULDIV_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) next_state = fast_hit ? MULDIV_DONE : MULDIV_CALC;
      end
      MULDIV_CALC: begin
        if (count_q == LAST_STEP) next_state = MULDIV_DONE;
      end
      MULDIV_DONE: begin
        o_valid = 1'b1;
        if (i_ready) next_state = MULDIV_IDLE;
      end
      default: next_state = MULDIV_IDLE;
    endcase
    if (i_flush) next_state = MULDIV_IDLE;
  end

  // Multiply iterates over the multiplier in lo; divide shifts the dividend out of lo.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      command_q <= MUL;
      hi_q      <= '0;
      lo_q      <= '0;
      operand_q <= '0;
      count_q   <= '0;
      negate_q  <= 1'b0;
      o_result  <= '0;
    end else if (accept) begin
      command_q <= i_command;
      hi_q      <= '0;
      lo_q      <= is_mul_command(i_command) ? rs2_mag : rs1_mag;
      operand_q <= is_mul_command(i_command) ? rs1_mag : rs2_mag;
      count_q   <= '0;
      negate_q  <= negate_d;
`ifdef RICE_CORE_MULDIV_FAST_PATH_EN
      if (fast_hit) o_result <= fast_result;
`endif
    end else if (step_en) begin
      hi_q    <= step_hi;
      lo_q    <= step_lo;
      count_q <= count_q + 1'b1;
      if (last_step) o_result <= final_result;
    end
  end

endmodule

// File: tb/tb_rice_core_muldiv.sv
// Randomized self-checking bench for rice_core_muldiv against an arithmetic reference model.
module tb_rice_core_muldiv;
  import rice_core_pkg::*;

  localparam int XLEN = 32;

  logic                    i_clk = 1'b0;
  logic                    i_rst = 1'b1;
  logic                    i_flush = 1'b0;
  logic                    i_valid = 1'b0;
  logic                    o_ready;
  logic [XLEN-1:0]         i_rs1_value = '0;
  logic [XLEN-1:0]         i_rs2_value = '0;
  rice_core_muldiv_command i_command = MUL;
  logic                    o_valid;
  logic                    i_ready = 1'b0;
  logic [XLEN-1:0]         o_result;

  int vectors = 0;
  int miscompares = 0;

  rice_core_muldiv #(.XLEN(XLEN)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_rs1_value(i_rs1_value),
    .i_rs2_value(i_rs2_value),
    .i_command  (i_command),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference results straight from the ISA rules using wide integer arithmetic.
  function automatic logic [31:0] refModel(input rice_core_muldiv_command cmd, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (cmd)
      MUL:    begin p = 64'(sa * sb); return p[31:0]; end
      MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      MULHSU: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
      MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

`ifdef RICE_CORE_MULDIV_FAST_PATH_EN
  function automatic bit isFastCorner(input rice_core_muldiv_command cmd, input logic [31:0] a, input logic [31:0] b);
    if (cmd inside {MUL, MULH, MULHSU, MULHU}) return (a == 0) || (b == 0);
    if (b == 0) return 1'b1;
    return (cmd inside {DIV, REM}) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction
`endif

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
  task automatic applyStimulus(input rice_core_muldiv_command cmd, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] expected;
    int lat;
    int expLat;
    expected = refModel(cmd, a, b);
    expLat = XLEN + 1;
`ifdef RICE_CORE_MULDIV_FAST_PATH_EN
    if (isFastCorner(cmd, a, b)) expLat = 1;
`endif
    checkOutput("ready_idle", o_ready, 1);
    i_command   = cmd;
    i_rs1_value = a;
    i_rs2_value = b;
    i_valid     = 1'b1;
    i_ready     = 1'b0;
    @(negedge i_clk);
    i_valid     = 1'b0;
    i_rs1_value = $urandom;
    i_rs2_value = $urandom;
    i_command   = rice_core_muldiv_command'($urandom_range(0, 7));
    lat = 1;
    if (expLat > 1) checkOutput("ready_busy", o_ready, 0);
    while (!o_valid && lat < 200) begin
      @(negedge i_clk);
      lat++;
    end
    checkOutput("valid_rise", o_valid, 1);
    checkOutput("latency", 64'(lat), 64'(expLat));
    checkOutput($sformatf("result_%s", cmd.name()), o_result, expected);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) @(negedge i_clk);
      checkOutput("hold_valid", o_valid, 1);
      checkOutput("hold_result", o_result, expected);
      checkOutput("hold_ready", o_ready, 0);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    checkOutput("valid_drop", o_valid, 0);
  endtask

  initial begin
    bit sawValid;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    checkOutput("reset_ready", o_ready, 1);
    checkOutput("reset_valid", o_valid, 0);
    checkOutput("reset_result", o_result, 0);

    applyStimulus(MUL, 32'd7, 32'hFFFF_FFFD, 0);
    applyStimulus(MULH, 32'h8000_0000, 32'h8000_0000, 0);
    applyStimulus(MULHSU, 32'h8000_0000, 32'h8000_0000, 0);
    applyStimulus(MULHU, 32'h8000_0000, 32'h8000_0000, 0);
    applyStimulus(DIV, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(REM, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(DIVU, 32'hFFFF_FFFF, 32'h10, 0);
    applyStimulus(DIVU, 32'h1234, 32'h0, 0);
    applyStimulus(REM, 32'h1234, 32'h0, 0);
    applyStimulus(DIV, 32'hFFFF_FFF9, 32'h0, 0);
    applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(MUL, 32'h0, 32'h1234_5678, 0);
    applyStimulus(MUL, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    applyStimulus(MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0);

    // Flush five steps into a calculation.
    i_command = DIVU; i_rs1_value = 32'd1000; i_rs2_value = 32'd3; i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (5) @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    checkOutput("flush_ready", o_ready, 1);
    sawValid = o_valid;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      sawValid |= o_valid;
    end
    checkOutput("flush_no_valid", sawValid, 0);

    // A request alongside flush is dropped.
    i_command = MUL; i_rs1_value = 32'd5; i_rs2_value = 32'd6; i_valid = 1'b1; i_flush = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0; i_flush = 1'b0;
    checkOutput("flush_req_ready", o_ready, 1);
    applyStimulus(DIVU, 32'd100, 32'd7, 0);

    // Asynchronous reset mid-calculation.
    i_command = MUL; i_rs1_value = 32'd3; i_rs2_value = 32'd4; i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    checkOutput("rst_ready", o_ready, 1);
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_result", o_result, 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int n = 0; n < 40; n++) begin
      applyStimulus(rice_core_muldiv_command'($urandom_range(0, 7)), pickOperand(), pickOperand(), (n % 7 == 0) ? 3 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rice_core_muldiv.md
Name: rice_core_muldiv

Overview:
- Parametrised iterative multiply/divide unit; implements the full RV M-extension operation set alongside the combinational ALU in the execute stage.
- Radix-2 shift-add multiplier and restoring divider share one datapath.
- Valid/ready handshake on both sides.
- Flush input abandons in-flight work on pipeline redirect.

Parameters:
- XLEN, 32, operand/result width (32 or 64).

Ports:
- i_clk  input  1  clock
- i_rst  input  1  asynchronous, active-high reset
- i_flush  input  1  abort current operation, return to IDLE
- i_valid  input  1  request valid
- o_ready  output  1  unit can accept a request
- i_rs1_value  input  XLEN  operand 1 (multiplicand/dividend)
- i_rs2_value  input  XLEN  operand 2 (multiplier/divisor)
- i_command  input  rice_core_muldiv_command  MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts result
- o_result  output  XLEN  result

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous, active-high. Reset values: state=IDLE, o_ready=1, o_valid=0, o_result=0, all datapath registers 0.
- FSM states IDLE, CALC, DONE:
  - IDLE: o_ready=1. i_valid=1 with i_flush=0 -> latch command, operand magnitudes and result-sign flags; step counter=0; go to CALC.
  - CALC: o_ready=0. One radix-2 step per cycle, XLEN steps. Counter is log2(XLEN)+1 bits. After step XLEN-1, apply sign correction and register o_result; go to DONE.
  - DONE: o_valid=1, o_result stable. i_ready=1 -> IDLE. No new accept in the same cycle; next accept is possible the cycle after.
- Latency: accept at cycle 0 -> o_valid at cycle XLEN+1 (33 for XLEN=32). Throughput: one op per XLEN+2 cycles minimum.
- Multiply: 2*XLEN-bit unsigned product of magnitudes, negated if the sign flag is set.
  - MUL: low XLEN bits.
  - MULH: high XLEN bits, signed x signed.
  - MULHSU: high XLEN bits, signed rs1 x unsigned rs2.
  - MULHU: high XLEN bits, unsigned x unsigned.
- Divide: restoring, unsigned on magnitudes.
  - Quotient sign = sign(rs1) xor sign(rs2) for DIV.
  - Remainder sign = sign(rs1) for REM.
  - DIVU/REMU use raw operands.
- Divisor zero: quotient = all ones; remainder = rs1 unmodified. Applies to signed and unsigned forms.
- Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): DIV result = rs1; REM result = 0.
- Corner cases are selected at the DONE transition; the datapath still runs XLEN cycles unless the optional feature is enabled.
- i_flush: in any state, next state = IDLE, o_valid=0, o_ready=1. A request presented together with i_flush is not accepted. Flush has priority over handshake.
- o_valid is held with o_result stable until i_ready=1. A stalled consumer holds the unit in DONE indefinitely.
- Unknown command values behave as MUL.

Optional Feature:
- Macro: RICE_CORE_MULDIV_FAST_PATH_EN.
- Defined: the following bypass CALC and enter DONE on the cycle after accept (o_valid at cycle 1):
  - divide by zero
  - signed divide overflow
  - multiply with either operand zero
- Undefined: every operation takes the full XLEN+1 cycles. Results are identical in both builds.

Decomposition:
- rice_core_pkg additions:
  - rice_core_muldiv_command enum (3 bits, MUL=0 ... REMU=7).
  - Helper functions is_mul_command and is_signed_rs1/is_signed_rs2.
- Sub-module rice_core_muldiv_step: combinational single radix-2 step (shift-add or trial-subtract) on the {hi,lo} accumulator. The FSM and sign correction stay in the top module.

Test Plan:
- MUL, rs1=7, rs2=-3 (0xFFFFFFFD), XLEN=32 -> o_result=0xFFFFFFEB, o_valid exactly 33 cycles after accept.
- MULH/MULHSU/MULHU with rs1=rs2=0x80000000 -> 0x40000000 / 0xC0000000 / 0x40000000.
- DIV rs1=-7, rs2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF.
- DIVU/REM with rs2=0, rs1=0x1234 -> 0xFFFFFFFF / 0x1234. DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000, REM -> 0. With RICE_CORE_MULDIV_FAST_PATH_EN, o_valid appears 1 cycle after accept.
- Hold i_ready=0 for 10 cycles in DONE -> o_valid and o_result stable, o_ready=0. Release -> o_ready=1 the next cycle, back-to-back request accepted.
- Assert i_flush at CALC step 5 -> o_valid never rises, o_ready=1 next cycle. Subsequent DIVU 100/7 returns 14. Assert i_rst mid-CALC -> all outputs at reset values immediately.
